// File: rtl/i2s_serializer_if.sv
// Upstream sample-pair handshake into i2s_serializer.
// A transfer happens on a clk edge where s_valid_i && s_ready_o.
interface i2s_serializer_if;
    localparam int unsigned SAMPLE_W = 16;

    logic                s_valid_i;
    logic                s_ready_o;
    logic [SAMPLE_W-1:0] s_left_i;
    logic [SAMPLE_W-1:0] s_right_i;

    modport master (output s_valid_i, s_left_i, s_right_i, input s_ready_o);
    modport slave  (input s_valid_i, s_left_i, s_right_i, output s_ready_o);
endinterface

// File: rtl/i2s_serializer.sv
// I2S stereo transmitter: phase-accumulator BCK, one-pair holding register, 32-slot frame.
// Optional macro I2S_UNDERRUN_HOLD_EN: on underrun repeat the last frame instead of silence.
module i2s_serializer #(
    parameter int unsigned CLK_HZ = 6000000,
    parameter int unsigned BCK_HZ = 1411200,
    parameter int unsigned ACC_W  = 25
) (
    input  logic            clk,
    input  logic            sys_rst_i,
    i2s_serializer_if.slave s_if,
    output logic            i2s_bck_o,
    output logic            i2s_lrck_o,
    output logic            i2s_din_o,
    output logic            frame_o,
    output logic            underrun_o
);
    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned FRAME_W = 32;

    // Signed step sizes, truncated to the accumulator width (two's complement wrap).
    localparam longint INC_TICK_L = 2 * longint'(BCK_HZ) - longint'(CLK_HZ);
    localparam longint INC_IDLE_L = 2 * longint'(BCK_HZ);
    localparam logic [ACC_W-1:0] INC_TICK = ACC_W'(INC_TICK_L);
    localparam logic [ACC_W-1:0] INC_IDLE = ACC_W'(INC_IDLE_L);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(31);
    localparam logic [SLOT_W-1:0] LR_FIRST  = SLOT_W'(15);
    localparam logic [SLOT_W-1:0] LR_LAST   = SLOT_W'(30);

    logic [ACC_W-1:0]   acc;
    logic [SLOT_W-1:0]  slot;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] hold;
    logic               full;

    logic               tick_c;
    logic               fall_c;
    logic               load_c;
    logic               accept_c;
    logic [SLOT_W-1:0]  slot_nxt_c;
    logic [FRAME_W-1:0] underrun_frame_c;
    logic [FRAME_W-1:0] frame_nxt_c;

    // Tick/slot decode and the frame contents for the slot being entered.
    always_comb begin
        tick_c     = ~acc[ACC_W-1];
        fall_c     = tick_c & i2s_bck_o;
        load_c     = fall_c & (slot == SLOT_LAST);
        accept_c   = s_if.s_valid_i & ~full;
        slot_nxt_c = slot + SLOT_W'(1);
`ifdef I2S_UNDERRUN_HOLD_EN
        underrun_frame_c = frame;
`else
        underrun_frame_c = '0;
`endif
        frame_nxt_c = frame;
        if (load_c) begin
            frame_nxt_c = full ? hold : underrun_frame_c;
        end
    end

    assign s_if.s_ready_o = ~full;

    always_ff @(posedge clk) begin
        if (sys_rst_i) begin
            acc        <= '0;
            i2s_bck_o  <= 1'b0;
            i2s_lrck_o <= 1'b0;
            i2s_din_o  <= 1'b0;
            slot       <= SLOT_LAST;
            frame      <= '0;
            hold       <= '0;
            full       <= 1'b0;
            frame_o    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            acc <= acc + (tick_c ? INC_TICK : INC_IDLE);
            if (tick_c) begin
                i2s_bck_o <= ~i2s_bck_o;
            end
            // DIN/LRCK present the slot being entered; slot s carries frame bit 31-s.
            if (fall_c) begin
                slot       <= slot_nxt_c;
                frame      <= frame_nxt_c;
                i2s_din_o  <= frame_nxt_c[~slot_nxt_c];
                i2s_lrck_o <= (slot_nxt_c >= LR_FIRST) && (slot_nxt_c <= LR_LAST);
            end
            frame_o    <= load_c;
            underrun_o <= load_c & ~full;
            // Accept only happens while empty, so it safely outranks the clear.
            if (accept_c) begin
                full <= 1'b1;
                hold <= {s_if.s_left_i, s_if.s_right_i};
            end else if (load_c) begin
                full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_serializer.sv
// Self-checking bench for i2s_serializer: table of per-frame vectors plus
// backpressure, mid-frame reset and bit-rate sequences.
module tb_i2s_serializer;
    logic clk = 1'b0;
    logic sys_rst_i;
    logic bck, lrck, din, frame_o, underrun_o;

    i2s_serializer_if up();

    i2s_serializer dut (
        .clk       (clk),
        .sys_rst_i (sys_rst_i),
        .s_if      (up),
        .i2s_bck_o (bck),
        .i2s_lrck_o(lrck),
        .i2s_din_o (din),
        .frame_o   (frame_o),
        .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;
`ifdef I2S_UNDERRUN_HOLD_EN
    localparam logic [31:0] UR_A = 32'hA5F0_0F0F;
    localparam logic [31:0] UR_B = 32'h1234_8001;
    localparam logic [31:0] UR_C = 32'h5555_6666;
`else
    localparam logic [31:0] UR_A = 32'h0;
    localparam logic [31:0] UR_B = 32'h0;
    localparam logic [31:0] UR_C = 32'h0;
`endif

    typedef struct {
        bit          send;
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp_bits;
        bit          exp_ur;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;

    // Frame capture state (written by the monitor only).
    logic [31:0] q_bits[$];
    logic [31:0] q_lr[$];
    logic        q_ur[$];
    int          frame_cnt  = 0;
    int          mon_idx    = 0;
    bit          mon_active = 1'b0;
    logic        mon_bck_prev = 1'b0;
    logic [31:0] mon_bits, mon_lr;
    logic        mon_ur;
    int          xfer_cnt  = 0;
    int          stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic check_frame(input string name, input logic [31:0] exp_bits, input bit exp_ur);
        logic [31:0] b, l;
        logic        u;
        if (q_bits.size() == 0) begin
            n_checks++;
            $display("FAIL %s: no complete frame captured, expected %h", name, exp_bits);
        end else begin
            b = q_bits.pop_front();
            l = q_lr.pop_front();
            u = q_ur.pop_front();
            check({name, "_din"}, b, exp_bits);
            check({name, "_lrck"}, l, LR_PATTERN);
            check({name, "_underrun"}, 32'(u), 32'(exp_ur));
        end
    endtask

    task automatic wait_frames(input int target);
        int c = 0;
        while (frame_cnt < target && c < 2000) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (frame_cnt < target) begin
            n_checks++;
            $display("FAIL wait_frame: frame count %0d expected %0d", frame_cnt, target);
        end
    endtask

    // Hold valid until the pair is taken; returns on the negedge after the accepting edge.
    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        bit done = 1'b0;
        up.s_valid_i = 1'b1;
        up.s_left_i  = l;
        up.s_right_i = r;
        for (int c = 0; c < 1000 && !done; c++) begin
            done = up.s_ready_o;
            @(negedge clk);
        end
        up.s_valid_i = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_pair: pair %h_%h not accepted, ready %b", l, r, up.s_ready_o);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {26'b0, bck, lrck, din, frame_o, underrun_o, up.s_ready_o};
    endfunction

    // Frame monitor: DIN/LRCK sampled on each BCK rising edge, framed by frame_o.
    initial begin
        forever begin
            @(negedge clk);
            if (sys_rst_i) begin
                mon_active = 1'b0;
            end else if (frame_o) begin
                frame_cnt++;
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_ur     = underrun_o;
                mon_bits   = '0;
                mon_lr     = '0;
            end else if (mon_active && bck && !mon_bck_prev) begin
                mon_bits[31 - mon_idx] = din;
                mon_lr[31 - mon_idx]   = lrck;
                mon_idx++;
                if (mon_idx == 32) begin
                    q_bits.push_back(mon_bits);
                    q_lr.push_back(mon_lr);
                    q_ur.push_back(mon_ur);
                    mon_active = 1'b0;
                end
            end
            mon_bck_prev = bck;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!sys_rst_i && up.s_valid_i) begin
                if (up.s_ready_o) xfer_cnt++;
                else stall_cnt++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer0, stall0, c, rises, lr_rises, hp, hp_bad;
        logic pb, pl;
        bit seen;

        vecs[0] = '{1'b1, 16'hA5F0, 16'h0F0F, 32'h0000_0000, 1'b1};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 32'hA5F0_0F0F, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, UR_A,          1'b1};
        vecs[3] = '{1'b1, 16'h1234, 16'h8001, UR_A,          1'b1};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 32'h1234_8001, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, UR_B,          1'b1};

        up.s_valid_i = 1'b0;
        up.s_left_i  = '0;
        up.s_right_i = '0;
        sys_rst_i    = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_outputs_c%0d", i), out_vec(), 32'h1);
        end
        sys_rst_i = 1'b0;
        @(negedge clk);
        check("bck_first_rise", 32'(bck), 32'h1);

        // Table: each entry describes frame i and what is offered while it plays.
        wait_frames(1);
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].send) send_pair(vecs[i].l, vecs[i].r);
            wait_frames(i + 2);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].exp_ur);
        end

        // Backpressure: three pairs back to back starting in frame 6.
        xfer0  = xfer_cnt;
        stall0 = stall_cnt;
        send_pair(16'h1111, 16'h2222);
        send_pair(16'h3333, 16'h4444);
        send_pair(16'h5555, 16'h6666);
        wait_frames(12);
        check_frame("bp_f6", UR_B, 1'b1);
        check_frame("bp_p1", 32'h1111_2222, 1'b0);
        check_frame("bp_p2", 32'h3333_4444, 1'b0);
        check_frame("bp_p3", 32'h5555_6666, 1'b0);
        check_frame("bp_f10", UR_C, 1'b1);
        check("bp_xfers", 32'(xfer_cnt - xfer0), 32'd3);
        check("bp_stalled", 32'(stall_cnt > stall0), 32'h1);

        // Reset at slot 20 with a pair waiting in the holding register.
        xfer0 = xfer_cnt;
        send_pair(16'hDEAD, 16'hBEEF);
        c = 0;
        while (!(mon_active && mon_idx >= 21) && c < 500) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("midrst_reach_slot20", 32'(mon_active && mon_idx >= 21), 32'h1);
        sys_rst_i = 1'b1;
        @(negedge clk);
        check("midrst_outputs", out_vec(), 32'h1);
        sys_rst_i = 1'b0;
        @(negedge clk);
        check("midrst_bck_rise", 32'(bck), 32'h1);
        wait_frames(14);
        check_frame("midrst_discard", 32'h0, 1'b1);
        check("midrst_xfers", 32'(xfer_cnt - xfer0), 32'd1);

        // Rate: 40000 clk from reset is 9408 BCK periods and 294 frames.
        sys_rst_i = 1'b1;
        @(negedge clk);
        sys_rst_i = 1'b0;
        rises = 0; lr_rises = 0; hp = 0; hp_bad = 0;
        pb = 1'b0; pl = 1'b0; seen = 1'b0;
        for (int k = 0; k < 40000; k++) begin
            @(negedge clk);
            hp++;
            if (bck != pb) begin
                if (seen && (hp < 2 || hp > 3)) hp_bad++;
                seen = 1'b1;
                hp   = 0;
                if (bck) rises++;
            end
            if (lrck && !pl) lr_rises++;
            pb = bck;
            pl = lrck;
        end
        check_range("rate_bck_rises", rises, 9407, 9409);
        check_range("rate_lrck_periods", lr_rises, 293, 295);
        check("rate_half_period", 32'(hp_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
